// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//
// UART transmitter with a transmit FIFO in front of it and a periodic
// auto-send source. Producers push words without looking at busy. The frame
// engine pops the FIFO head, or falls back to a pending periodic request, and
// serialises the word as:
//   start bit (0), DATA_W data bits LSB first, optional parity, STOP_BITS stop bits (1).
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, a parity bit follows the data bits and the parameter
//   PARITY_ODD is added (0 = even parity, non-zero = odd parity).
//
// Parameters:
//   CLK_HZ      input clock frequency in Hz
//   BAUD        line rate; one bit lasts CLK_HZ / BAUD cycles
//   DATA_W      payload bits per frame (1..16)
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PERIOD_CYC  auto-send period in clock cycles (>= 2)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   wr_en         push wr_data into the FIFO
//   wr_data       word to queue
//   periodic_en   enables the periodic auto-send of periodic_data
//   periodic_data word sent on every period tick
//   clr_ovf       clears the sticky overflow flag
//   full          FIFO holds FIFO_DEPTH words
//   empty         FIFO holds no words
//   level         FIFO occupancy
//   overflow      sticky: a write was dropped because the FIFO was full
//   tx            serial line, idle high
//   busy          high while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_queue #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PERIOD_CYC = 50_000_000
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          periodic_en,
    input  logic [DATA_W-1:0]             periodic_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(DIV + 1);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int PER_W  = $clog2(PERIOD_CYC + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;

    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic              per_pend_q, per_pend_d;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              take_per;
    logic              bit_done;
    logic              try_start;
    logic [DATA_W-1:0] next_word;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);

    // Frame engine. A new frame may begin either from IDLE or straight out of
    // the last stop-bit cycle, which is what keeps back-to-back frames gapless.
    // The word is captured into the shift register at that moment, so later
    // changes on wr_data/periodic_data never disturb a frame in flight.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        take_per  = 1'b0;
        try_start = 1'b0;
        next_word = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        bit_done  = (baud_q == BAUD_LAST);

        if (state_q != ST_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                try_start = 1'b1;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        try_start = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The FIFO always wins over a periodic request; the request simply
        // stays pending until a frame slot is free with the FIFO empty.
        if (try_start) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                next_word = mem_q[rd_ptr_q];
                state_d   = ST_START;
                baud_d    = '0;
                shift_d   = next_word;
            end else if (per_pend_q) begin
                take_per  = 1'b1;
                next_word = periodic_data;
                state_d   = ST_START;
                baud_d    = '0;
                shift_d   = next_word;
            end
`ifdef UART_TX_PARITY_EN
            par_d = (^next_word) ^ (PARITY_ODD != 0);
`endif
        end
    end

    // FIFO bookkeeping. A write into a full FIFO is still accepted when the
    // frame engine pops in the same cycle; only a genuinely dropped write
    // raises overflow, and it beats a simultaneous clear.
    always_comb begin
        push     = wr_en && (!fifo_full || pop);
        drop     = wr_en && fifo_full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Periodic tick generator. Disabling it clears both the counter and any
    // pending request. A tick landing on an already pending request is simply
    // absorbed; a tick in the same cycle the request is served re-arms it.
    always_comb begin
        per_cnt_d  = '0;
        per_pend_d = 1'b0;
        if (periodic_en) begin
            per_pend_d = per_pend_q && !take_per;
            if (per_cnt_q == PER_LAST) begin
                per_cnt_d  = '0;
                per_pend_d = 1'b1;
            end else begin
                per_cnt_d = per_cnt_q + 1'b1;
            end
        end
    end

    // All state registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            per_cnt_q  <= '0;
            per_pend_q <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            per_cnt_q  <= per_cnt_d;
            per_pend_q <= per_pend_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // The line is decoded straight from the state flops, so reset drives it
    // back to idle-high immediately rather than on the next edge.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = par_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Parametrised UART transmitter with an internal transmit FIFO, configurable data width and stop-bit count, and a periodic auto-send mode. It replaces the single-shot 9-bit transmitter in the turret link. Producers such as the detection logic and the button handler push words without waiting on `busy`. The block sits between the detection/control logic and the board `uart_tx` pin.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `BAUD`, 115200, line rate; bit period `DIV = CLK_HZ / BAUD` (integer division, truncated).
- `DATA_W`, 9, payload bits per frame (1..16).
- `FIFO_DEPTH`, 8, FIFO entries; must be a power of two, at least 2.
- `STOP_BITS`, 1, stop bits per frame (1 or 2).
- `PERIOD_CYC`, 50_000_000, auto-send period in clock cycles, at least 2.
- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in `DATA_W`: word to queue.
- `periodic_en` in 1: enables auto-send of `periodic_data`.
- `periodic_data` in `DATA_W`: word sent on each period tick.
- `clr_ovf` in 1: clears `overflow`.
- `full` out 1: FIFO holds `FIFO_DEPTH` words.
- `empty` out 1: FIFO holds 0 words.
- `level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow` out 1: sticky flag; a write was dropped.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line.

## Operation
- **FIFO write:** when `wr_en=1` and `full=0`, `wr_data` is stored.
- **Dropped write:** when `wr_en=1` and `full=1`, the word is dropped and `overflow` is set.
- **Overflow clear:** `clr_ovf` clears `overflow`. If a drop occurs in the same cycle as `clr_ovf`, set wins.
- **Simultaneous push and pop:** when the FIFO is full, a push in the same cycle as a pop is accepted. `level` stays unchanged.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:**
  - IDLE → START when the FIFO is not empty (pop the head word) or a periodic request is pending (use `periodic_data`).
  - START → DATA.
  - DATA → PARITY (macro defined) or STOP.
  - PARITY → STOP.
  - STOP → START when another word or request is waiting, else IDLE.
- **Source priority:** the FIFO has priority over a periodic request. A pending periodic request stays pending until it is served.
- **Word capture:** the word to send is latched into the shift register on the IDLE/STOP → START transition. Later input changes do not affect the frame in progress.
- **Bit order:** start bit (0), `DATA_W` data bits LSB first, optional parity bit, then `STOP_BITS` stop bits (1).
- **Periodic counter:**
  - While `periodic_en=1`, a counter runs 0..`PERIOD_CYC-1`. On wrap it sets `per_pend`.
  - While `periodic_en=0`, the counter and `per_pend` are held at 0.
  - A tick that occurs while `per_pend` is already set is absorbed; ticks are not queued.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `full=0`, `empty=1`, `level=0`, `overflow=0`. FIFO contents, pointers, periodic counter and FSM are cleared.
- **Reset during a frame:** asserting reset mid-frame forces `tx=1` immediately. The frame is abandoned, not resumed.
- **Start latency:** `wr_en` sampled at edge N into an empty FIFO with the FSM in IDLE:
  - `level=1` after edge N;
  - pop, `tx=0` and `busy=1` after edge N+1.
- **Bit duration:** every bit lasts exactly `DIV` cycles. The baud counter restarts at 0 on each frame start.
- **Frame length:** `F = (1 + DATA_W + P + STOP_BITS) * DIV` cycles, where P=1 with parity and 0 without.
- **Back-to-back frames:** when another word is ready, the next start bit begins on the cycle after the last stop-bit cycle. There is no idle gap and `busy` stays high.
- **End of traffic:** with nothing waiting, `busy` falls and `tx` stays 1 after the final stop-bit cycle.
- **Periodic start:** `per_pend` set at edge N while IDLE produces a start bit after edge N+1.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:**
  - Adds parameter `PARITY_ODD` (default 0).
  - A parity bit is sent after the data bits. Even parity: the bit equals the XOR of the data bits. Odd parity: the inverted XOR.
  - Frame length includes the parity bit (P=1).
- **Not defined:** no PARITY state, no `PARITY_ODD` parameter, P=0.

## Test plan
Use `CLK_HZ=1_000_000`, `BAUD=100_000` (DIV=10), `DATA_W=9`, `FIFO_DEPTH=4`, `STOP_BITS=1`.

- **Single frame:** reset, then one `wr_en` with `9'h1A5` → `tx` low 10 cycles, then bits 1,0,1,0,0,1,0,1,1 of 10 cycles each, then stop; `busy` high for 110 cycles (120 with parity; parity bit 1 for even).
- **Burst and overflow:** 6 back-to-back writes (`9'h001`..`9'h006`) while the first frame is sending →
  - `full=1` after the fifth write;
  - the sixth write is dropped and `overflow=1`;
  - 5 frames are sent with no idle gap between them;
  - `clr_ovf` then clears `overflow`.
- **Periodic mode:** `periodic_en=1`, `PERIOD_CYC=300`, `periodic_data=9'h0FF` → a frame starts every 300 cycles; dropping `periodic_en` mid-period → no further frames.
- **Priority:** FIFO holds `9'h055` while `per_pend` is set → `9'h055` is sent first, then `9'h0FF` immediately after.
- **Reset mid-frame:** assert reset during data bit 4 → `tx=1` and `busy=0` at once, `level=0`; after release the line stays idle.
- **Simultaneous push/pop:** write into a full FIFO on the pop cycle → accepted, `overflow` stays 0, `level` stays 4.
